// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the framebuffer loader.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int RGB_W = 12;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/mem_loader_idle_timer.sv
// Mid-frame inactivity counter; expire is a combinational pulse in the cycle the count reaches TIMEOUT-1.
// Disabled or cleared, it holds at zero; it restarts from zero after expiring.
module idle_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable || expire) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Sync-framed byte stream to RGB444 framebuffer writes; write appears one cycle after the LO byte.
// oReady drops only in reset and in the single DONE cycle; the host holds its byte meanwhile.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int          FRAME_PIXELS = 19200,
  parameter int          ADDR_W       = 15,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
  parameter int          TIMEOUT      = 1000000
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [7:0]        iData,
  input  logic              iValid,
  output logic              oReady,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [RGB_W-1:0]  oWrData,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic              oError
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   idx, idx_n;
  logic [3:0]          red, red_n;
  logic                wr_en_n, done_n, err_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [RGB_W-1:0]    wr_data_n;
  logic                accept, expire, in_frame;

  assign oReady   = !iRst && (state != DONE);
  assign oBusy    = (state != IDLE);
  assign accept   = iValid && oReady;
  assign in_frame = (state == HI) || (state == LO);

  // Every state entry into HI/LO coincides with an accept, so accept alone clears the timer.
  idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (iClk),
    .rst    (iRst),
    .clear  (accept),
    .enable (in_frame),
    .expire (expire)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    red_n     = red;
    wr_en_n   = 1'b0;
    wr_addr_n = oWrAddr;
    wr_data_n = oWrData;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && iData == SYNC_BYTE) begin
          state_n = HI;
          idx_n   = '0;
        end
      end
      HI: begin
        if (accept) begin
          if (iData[7:4] == 4'h0) begin
            red_n   = iData[3:0];
            state_n = LO;
          end else begin
            state_n = IDLE;
            idx_n   = '0;
            err_n   = 1'b1;
          end
        end else if (expire) begin
          state_n = IDLE;
          idx_n   = '0;
          err_n   = 1'b1;
        end
      end
      LO: begin
        if (accept) begin
          wr_en_n   = 1'b1;
          wr_addr_n = idx;
          wr_data_n = {red, iData};
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + ADDR_W'(1);
            state_n = HI;
          end
        end else if (expire) begin
          state_n = IDLE;
          idx_n   = '0;
          err_n   = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
        done_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      idx        <= '0;
      red        <= '0;
      oWrEn      <= 1'b0;
      oWrAddr    <= '0;
      oWrData    <= '0;
      oFrameDone <= 1'b0;
      oError     <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      red        <= red_n;
      oWrEn      <= wr_en_n;
      oWrAddr    <= wr_addr_n;
      oWrData    <= wr_data_n;
      oFrameDone <= done_n;
      oError     <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a 4-pixel frame and a 16-cycle idle timeout.
module tb_mem_loader;

  logic        iClk;
  logic        iRst;
  logic [7:0]  iData;
  logic        iValid;
  logic        oReady;
  logic        oWrEn;
  logic [14:0] oWrAddr;
  logic [11:0] oWrData;
  logic        oBusy;
  logic        oFrameDone;
  logic        oError;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int wr_cnt  = 0;
  int base;

  logic [7:0]  gb_hi  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0]  gb_lo  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [11:0] gb_exp [4] = '{12'h111, 12'h222, 12'h333, 12'h444};

  mem_loader #(
    .FRAME_PIXELS (4),
    .ADDR_W       (15),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT      (16)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iData      (iData),
    .iValid     (iValid),
    .oReady     (oReady),
    .oWrEn      (oWrEn),
    .oWrAddr    (oWrAddr),
    .oWrData    (oWrData),
    .oBusy      (oBusy),
    .oFrameDone (oFrameDone),
    .oError     (oError)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    if (oWrEn === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    iValid = 1'b1;
    iData  = b;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [14:0] addr, input logic [11:0] data);
    chk({tag, "_en"},   32'(oWrEn),   32'd1);
    chk({tag, "_addr"}, 32'(oWrAddr), 32'(addr));
    chk({tag, "_data"}, 32'(oWrData), 32'(data));
  endtask

  initial begin
    iRst   = 1'b1;
    iValid = 1'b0;
    iData  = 8'h00;
    tick();
    tick();
    chk("rst_ready", 32'(oReady), 0);
    chk("rst_wren",  32'(oWrEn), 0);
    chk("rst_addr",  32'(oWrAddr), 0);
    chk("rst_data",  32'(oWrData), 0);
    chk("rst_busy",  32'(oBusy), 0);
    chk("rst_done",  32'(oFrameDone), 0);
    chk("rst_err",   32'(oError), 0);
    iRst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(oReady), 1);

    // Full frame with iValid held high
    base = wr_cnt;
    send(8'hA5);
    chk("ff_busy", 32'(oBusy), 1);
    send(8'h0F);
    send(8'h12);
    chk_wr("ff_px0", 15'd0, 12'hF12);
    send(8'h03);
    chk("ff_hold_en",   32'(oWrEn), 0);
    chk("ff_hold_addr", 32'(oWrAddr), 0);
    chk("ff_hold_data", 32'(oWrData), 32'h0F12);
    send(8'h45);
    chk_wr("ff_px1", 15'd1, 12'h345);
    send(8'h0A);
    send(8'hBC);
    chk_wr("ff_px2", 15'd2, 12'hABC);
    send(8'h00);
    send(8'hFF);
    chk_wr("ff_px3", 15'd3, 12'h0FF);
    chk("ff_done_ready", 32'(oReady), 0);
    chk("ff_done_busy",  32'(oBusy), 1);
    chk("ff_done_early", 32'(oFrameDone), 0);
    // Byte offered during DONE must wait one cycle
    iData = 8'hA5;
    tick();
    chk("ff_fdone",    32'(oFrameDone), 1);
    chk("ff_fd_err",   32'(oError), 0);
    chk("ff_fd_ready", 32'(oReady), 1);
    chk("bp_not_taken", 32'(oBusy), 0);
    chk("ff_wr_count", 32'(wr_cnt - base), 4);
    tick();
    chk("bp_taken", 32'(oBusy), 1);
    chk("ff_fdone_pulse", 32'(oFrameDone), 0);

    // Mid-frame reset after the HI byte of pixel 2
    send(8'h01);
    send(8'h23);
    chk_wr("mr_px0", 15'd0, 12'h123);
    send(8'h04);
    send(8'h56);
    chk_wr("mr_px1", 15'd1, 12'h456);
    send(8'h07);
    iRst  = 1'b1;
    iData = 8'h89;
    tick();
    chk("mr_wren",  32'(oWrEn), 0);
    chk("mr_addr",  32'(oWrAddr), 0);
    chk("mr_data",  32'(oWrData), 0);
    chk("mr_busy",  32'(oBusy), 0);
    chk("mr_ready", 32'(oReady), 0);
    chk("mr_done",  32'(oFrameDone), 0);
    chk("mr_err",   32'(oError), 0);
    iRst   = 1'b0;
    iValid = 1'b0;
    tick();
    chk("mr_after_wren",  32'(oWrEn), 0);
    chk("mr_after_ready", 32'(oReady), 1);

    // Garbage before sync
    base = wr_cnt;
    send(8'h00);
    send(8'h3C);
    chk("gb_busy", 32'(oBusy), 0);
    send(8'hA5);
    chk("gb_sync", 32'(oBusy), 1);
    chk("gb_nowrites", 32'(wr_cnt - base), 0);
    for (int i = 0; i < 4; i++) begin
      send(gb_hi[i]);
      send(gb_lo[i]);
      chk_wr("gb_px", 15'(i), gb_exp[i]);
    end
    iValid = 1'b0;
    tick();
    chk("gb_fdone", 32'(oFrameDone), 1);
    chk("gb_wr_count", 32'(wr_cnt - base), 4);

    // Bad high byte: stray sync aborts
    send(8'hA5);
    send(8'h0F);
    send(8'h12);
    chk_wr("bad_px0", 15'd0, 12'hF12);
    send(8'hA5);
    chk("bad_err",   32'(oError), 1);
    chk("bad_busy",  32'(oBusy), 0);
    chk("bad_ready", 32'(oReady), 1);
    chk("bad_wren",  32'(oWrEn), 0);
    chk("bad_fdone", 32'(oFrameDone), 0);
    send(8'hA5);
    chk("bad_err_pulse", 32'(oError), 0);
    chk("bad_resync",    32'(oBusy), 1);
    send(8'h05);
    send(8'h67);
    chk_wr("bad_next_px0", 15'd0, 12'h567);
    send(8'h08);
    send(8'h9A);
    send(8'h0B);
    send(8'hCD);
    send(8'h0E);
    send(8'hF0);
    chk_wr("bad_next_px3", 15'd3, 12'hEF0);
    iValid = 1'b0;
    tick();
    chk("bad_next_fdone", 32'(oFrameDone), 1);

    // Idle timeout in LO
    send(8'hA5);
    send(8'h0F);
    iValid = 1'b0;
    repeat (15) tick();
    chk("to_not_yet", 32'(oError), 0);
    chk("to_busy",    32'(oBusy), 1);
    tick();
    chk("to_err",   32'(oError), 1);
    chk("to_idle",  32'(oBusy), 0);
    chk("to_ready", 32'(oReady), 1);
    tick();
    chk("to_err_pulse", 32'(oError), 0);
    send(8'hA5);
    chk("to_resync", 32'(oBusy), 1);
    send(8'h0F);
    send(8'h12);
    chk_wr("to_next_px0", 15'd0, 12'hF12);
    iValid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Framebuffer loader feeding the colour memory of the VGA path. It accepts a byte stream from a host link (UART receiver or similar) over a valid/ready handshake and frames it with a sync byte. It assembles RGB444 pixels from byte pairs and writes them to the framebuffer write port at sequential addresses. The VGA read side (counters, memory, colour stage) is untouched; this block owns the memory's write port only.

## Interface
- FRAME_PIXELS, 19200, pixels per frame (160x120); valid range 2..2**ADDR_W
- ADDR_W, 15, framebuffer address width
- SYNC_BYTE, 8'hA5, frame-start marker
- TIMEOUT, 1000000, idle cycles mid-frame before abort; minimum 2
- Reset: one clock; reset is synchronous and active-high.
- iClk  in  1  system clock
- iRst  in  1  synchronous active-high reset
- iData  in  8  stream byte
- iValid  in  1  iData valid
- oReady  out  1  block can accept a byte this cycle
- oWrEn  out  1  framebuffer write strobe, one cycle per pixel
- oWrAddr  out  ADDR_W  pixel address
- oWrData  out  12  pixel {R[3:0], G[3:0], B[3:0]}
- oBusy  out  1  frame in progress (state HI, LO or DONE)
- oFrameDone  out  1  one-cycle pulse, full frame written
- oError  out  1  one-cycle pulse, frame aborted

## Operation
- Byte accepted iff iValid && oReady at the iClk edge.
- oReady = !iRst && state in {IDLE, HI, LO}. It is combinational from state.
- States and transitions:
  - IDLE: an accepted byte equal to SYNC_BYTE goes to HI with pixel index 0. Any other byte is discarded silently.
  - HI: an accepted byte with upper nibble 0 latches R = iData[3:0] and goes to LO.
  - HI: an accepted byte with upper nibble nonzero aborts the frame. This includes a stray SYNC_BYTE.
  - LO: an accepted byte supplies {G, B} = iData. The block issues a write of {R, G, B} at the current index.
  - LO, after the write: if the index == FRAME_PIXELS-1, go to DONE. Otherwise increment the index and go to HI.
  - DONE: lasts one cycle, then returns to IDLE with index 0.
- Abort: go to IDLE, index 0, pulse oError. Pixels already written stay in memory; there is no rollback.
- Idle timeout: a counter runs in HI and LO. It clears on every accepted byte and on every state entry. When it reaches TIMEOUT-1 without an accept, the block aborts.
- The index width is ADDR_W and the index never wraps inside a frame. DONE is the only way back to 0 besides abort and reset.

## Timing
- Reset values: state IDLE, index 0, timer 0, oWrEn 0, oWrAddr 0, oWrData 0, oBusy 0, oFrameDone 0, oError 0. oReady is 0 while iRst is high and 1 in the first cycle after release.
- Write latency: LO byte accepted at edge N gives oWrEn=1 with the matching oWrAddr and oWrData during cycle N+1. oWrAddr and oWrData hold their values when oWrEn=0.
- Streaming needs no stall. A new HI byte may be accepted at edge N+1 while the previous write is on the port. Peak throughput is one pixel per 2 cycles.
- Last pixel: LO accepted at N. During N+1 the state is DONE, oReady=0 and oWrEn=1. During N+2, oFrameDone=1 and the state is IDLE with oReady=1.
- oError is high during the cycle after the offending accept or timeout expiry. oFrameDone and oError never coincide.
- iRst high mid-frame forces the reset values at that edge. There is no write, no oError and no oFrameDone. A write strobe already registered for the following cycle is cancelled.
- iValid with oReady=0 is ignored and no data is lost. The host must hold the byte.

## Structure
- Package mem_loader_pkg holds:
  - the state enum (IDLE, HI, LO, DONE)
  - the RGB444 width constant (12)
  - the default SYNC_BYTE
- Sub-module idle_timer holds the TIMEOUT counter. Its ports are clear, enable and an expire pulse; its width is $clog2(TIMEOUT).
- The FSM, index register and output registers live in mem_loader.

## Test plan
- All tests override FRAME_PIXELS=4 and TIMEOUT=16.
- Full frame: A5, 0F, 12, 03, 45, 0A, BC, 00, FF with iValid held high. Required response:
  - writes (0,F12), (1,345), (2,ABC), (3,0FF), each one cycle after its LO byte
  - oFrameDone pulses two cycles after the last accept
  - exactly 4 oWrEn pulses
- Pre-sync garbage: 00, 3C, A5 followed by a valid frame gives no writes before the sync byte and a normal frame afterwards.
- Bad high byte: A5, 0F, 12, A5. Required response:
  - one write (0,F12)
  - oError pulses after the 4th byte
  - the state is IDLE and the next frame starts at address 0
- Timeout: A5, 0F, then iValid low for 16 cycles. oError pulses once and oBusy falls; the following A5 is accepted as a sync.
- Backpressure and reset: hold iValid during the DONE cycle and check that the byte is accepted only on the following cycle. Assert iRst after the HI byte of pixel 2 and check that there is no write and that all outputs are at their reset values.
